// File: rtl/dcache_wb_controller_if.sv
// Bus bundle for the data-cache controller: the LSU request/response port
// plus the AXI-style write-back (AW/W/B) and refill (AR/R) channels.
// Handshake rule on every channel: a transfer happens on the rising edge
// where valid and ready are both 1. The sender holds valid and its payload
// stable until that edge. The LSU side has no response ready because the
// LSU is always ready.
interface dcache_wb_controller_if;
    // LSU request / response
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_wstrb;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    // write-back address / data / response
    logic [31:0] m_awaddr;
    logic [7:0]  m_awlen;
    logic        m_awvalid;
    logic        m_awready;
    logic [63:0] m_wdata;
    logic [7:0]  m_wstrb;
    logic        m_wlast;
    logic        m_wvalid;
    logic        m_wready;
    logic        m_bvalid;
    logic        m_bready;
    // refill address / data
    logic [31:0] m_araddr;
    logic [7:0]  m_arlen;
    logic        m_arvalid;
    logic        m_arready;
    logic [63:0] m_rdata;
    logic        m_rlast;
    logic        m_rvalid;
    logic        m_rready;

    // cache controller side
    modport master (
        input  req_valid, req_we, req_addr, req_wdata, req_wstrb,
        output req_ready, resp_valid, resp_rdata,
        output m_awaddr, m_awlen, m_awvalid, input m_awready,
        output m_wdata, m_wstrb, m_wlast, m_wvalid, input m_wready,
        input  m_bvalid, output m_bready,
        output m_araddr, m_arlen, m_arvalid, input m_arready,
        input  m_rdata, m_rlast, m_rvalid, output m_rready
    );

    // LSU + memory side
    modport slave (
        output req_valid, req_we, req_addr, req_wdata, req_wstrb,
        input  req_ready, resp_valid, resp_rdata,
        input  m_awaddr, m_awlen, m_awvalid, output m_awready,
        input  m_wdata, m_wstrb, m_wlast, m_wvalid, output m_wready,
        output m_bvalid, input m_bready,
        input  m_araddr, m_arlen, m_arvalid, output m_arready,
        output m_rdata, m_rlast, m_rvalid, input m_rready
    );
endinterface

// File: rtl/dcache_wb_controller.sv
// Direct-mapped, write-back, write-allocate data cache controller.
// Valid/dirty bits live in flops. Tag and line data live in a synchronous
// single-port RAM with a one-cycle read latency. The RAM is write-first, so
// the line written in REFILL_WR is on the read port in the following LOOKUP.
// Only one miss can be outstanding at a time. The AXI channels are used
// strictly one after another: AW, then W, then B, then AR, then R.
module dcache_wb_controller #(
    parameter int LINE_INDEX_WIDTH = 8,
    parameter int WORD_INDEX_WIDTH = 3
) (
    input  logic                    clk,
    input  logic                    rst,
    dcache_wb_controller_if.master  bus
);
    localparam int TAG_WIDTH  = 30 - LINE_INDEX_WIDTH - WORD_INDEX_WIDTH;
    localparam int LINES      = 2 ** LINE_INDEX_WIDTH;
    localparam int WORDS      = 2 ** WORD_INDEX_WIDTH;
    localparam int BEATS      = WORDS / 2;
    localparam int LINE_BITS  = 32 * WORDS;
    localparam int LINE_BYTES = 4 * WORDS;
    localparam int OFF_W      = WORD_INDEX_WIDTH + 2;
    localparam int BEAT_W     = (WORD_INDEX_WIDTH > 1) ? WORD_INDEX_WIDTH - 1 : 1;
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);

    typedef enum logic [2:0] {
        IDLE, LOOKUP, WB_AW, WB_W, WB_B, REFILL_AR, REFILL_R, REFILL_WR
    } state_t;

    state_t                      state_q, state_d;
    logic [29:0]                 addr_q, addr_d;      // word address of the request
    logic                        we_q, we_d;
    logic [31:0]                 wdata_q, wdata_d;
    logic [3:0]                  wstrb_q, wstrb_d;
    logic [BEAT_W-1:0]           beat_q, beat_d;
    logic [LINE_BITS-1:0]        line_q, line_d;      // victim / refill line buffer
    logic [TAG_WIDTH-1:0]        vtag_q, vtag_d;      // victim tag for write-back
    logic [LINES-1:0]            valid_q, valid_d;
    logic [LINES-1:0]            dirty_q, dirty_d;
    logic                        resp_valid_q, resp_valid_d;
    logic [31:0]                 resp_rdata_q, resp_rdata_d;

    // RAM port
    logic [LINE_INDEX_WIDTH-1:0] ram_idx;
    logic [LINE_BYTES-1:0]       ram_be;
    logic [LINE_BITS-1:0]        ram_wdata;
    logic                        tag_we;
    logic [LINE_BITS-1:0]        ram_rdata_q;
    logic [TAG_WIDTH-1:0]        tag_rdata_q;
    logic [LINE_BITS-1:0]        data_mem [LINES];
    logic [TAG_WIDTH-1:0]        tag_mem  [LINES];

    // address fields of the latched request
    logic [WORD_INDEX_WIDTH-1:0] addr_word;
    logic [LINE_INDEX_WIDTH-1:0] addr_idx;
    logic [TAG_WIDTH-1:0]        addr_tag;
    logic                        hit;
    logic                        unused_addr_bits;

    assign addr_word = addr_q[WORD_INDEX_WIDTH-1:0];
    assign addr_idx  = addr_q[WORD_INDEX_WIDTH+LINE_INDEX_WIDTH-1:WORD_INDEX_WIDTH];
    assign addr_tag  = addr_q[29:WORD_INDEX_WIDTH+LINE_INDEX_WIDTH];
    assign hit       = valid_q[addr_idx] && (tag_rdata_q == addr_tag);
    assign unused_addr_bits = &{1'b0, bus.req_addr[1:0]};

    // Next-state, datapath and RAM-port control for the miss/hit FSM
    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        we_d         = we_q;
        wdata_d      = wdata_q;
        wstrb_d      = wstrb_q;
        beat_d       = beat_q;
        line_d       = line_q;
        vtag_d       = vtag_q;
        valid_d      = valid_q;
        dirty_d      = dirty_q;
        resp_valid_d = 1'b0;
        resp_rdata_d = '0;
        ram_idx      = addr_idx;
        ram_be       = '0;
        ram_wdata    = line_q;
        tag_we       = 1'b0;
        case (state_q)
            IDLE: begin
                // start the tag/data read right away so LOOKUP sees it
                ram_idx = bus.req_addr[OFF_W+LINE_INDEX_WIDTH-1:OFF_W];
                if (bus.req_valid) begin
                    addr_d  = bus.req_addr[31:2];
                    we_d    = bus.req_we;
                    wdata_d = bus.req_wdata;
                    wstrb_d = bus.req_wstrb;
                    state_d = LOOKUP;
                end
            end
            LOOKUP: begin
                if (hit) begin
                    if (we_q) begin
                        ram_be[int'(addr_word)*4 +: 4] = wstrb_q;
                        ram_wdata          = {WORDS{wdata_q}};
                        dirty_d[addr_idx]  = 1'b1;
                    end else begin
                        resp_rdata_d = ram_rdata_q[int'(addr_word)*32 +: 32];
                    end
                    resp_valid_d = 1'b1;
                    state_d      = IDLE;
                end else begin
                    line_d  = ram_rdata_q;
                    vtag_d  = tag_rdata_q;
                    state_d = (valid_q[addr_idx] && dirty_q[addr_idx]) ? WB_AW : REFILL_AR;
                end
            end
            WB_AW: begin
                if (bus.m_awready) begin
                    beat_d  = '0;
                    state_d = WB_W;
                end
            end
            WB_W: begin
                if (bus.m_wready) begin
                    if (beat_q == LAST_BEAT) state_d = WB_B;
                    else                     beat_d  = beat_q + 1'b1;
                end
            end
            WB_B: begin
                if (bus.m_bvalid) state_d = REFILL_AR;
            end
            REFILL_AR: begin
                if (bus.m_arready) begin
                    beat_d  = '0;
                    state_d = REFILL_R;
                end
            end
            REFILL_R: begin
                if (bus.m_rvalid) begin
                    line_d[int'(beat_q)*64 +: 64] = bus.m_rdata;
                    beat_d = beat_q + 1'b1;
                    if (bus.m_rlast) state_d = REFILL_WR;
                end
            end
            REFILL_WR: begin
                ram_be            = '1;
                ram_wdata         = line_q;
                tag_we            = 1'b1;
                valid_d[addr_idx] = 1'b1;
                dirty_d[addr_idx] = 1'b0;
                state_d           = LOOKUP;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and registered-output flops; reset abandons any miss in flight
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            addr_q       <= '0;
            we_q         <= 1'b0;
            wdata_q      <= '0;
            wstrb_q      <= '0;
            beat_q       <= '0;
            line_q       <= '0;
            vtag_q       <= '0;
            valid_q      <= '0;
            dirty_q      <= '0;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= '0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            we_q         <= we_d;
            wdata_q      <= wdata_d;
            wstrb_q      <= wstrb_d;
            beat_q       <= beat_d;
            line_q       <= line_d;
            vtag_q       <= vtag_d;
            valid_q      <= valid_d;
            dirty_q      <= dirty_d;
            resp_valid_q <= resp_valid_d;
            resp_rdata_q <= resp_rdata_d;
        end
    end

    // Single-port write-first tag/data RAM with byte enables
    always_ff @(posedge clk) begin
        for (int b = 0; b < LINE_BYTES; b++) begin
            if (ram_be[b]) begin
                data_mem[ram_idx][b*8 +: 8] <= ram_wdata[b*8 +: 8];
                ram_rdata_q[b*8 +: 8]       <= ram_wdata[b*8 +: 8];
            end else begin
                ram_rdata_q[b*8 +: 8]       <= data_mem[ram_idx][b*8 +: 8];
            end
        end
        if (tag_we) begin
            tag_mem[ram_idx] <= addr_tag;
            tag_rdata_q      <= addr_tag;
        end else begin
            tag_rdata_q      <= tag_mem[ram_idx];
        end
    end

    // Channel outputs decode straight from state flops
    assign bus.req_ready  = (state_q == IDLE);
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_rdata = resp_rdata_q;
    assign bus.m_awvalid  = (state_q == WB_AW);
    assign bus.m_awaddr   = {vtag_q, addr_idx, {OFF_W{1'b0}}};
    assign bus.m_awlen    = 8'(BEATS - 1);
    assign bus.m_wvalid   = (state_q == WB_W);
    assign bus.m_wdata    = line_q[int'(beat_q)*64 +: 64];
    assign bus.m_wstrb    = 8'hFF;
    assign bus.m_wlast    = (state_q == WB_W) && (beat_q == LAST_BEAT);
    assign bus.m_bready   = (state_q == WB_B);
    assign bus.m_arvalid  = (state_q == REFILL_AR);
    assign bus.m_araddr   = {addr_tag, addr_idx, {OFF_W{1'b0}}};
    assign bus.m_arlen    = 8'(BEATS - 1);
    assign bus.m_rready   = (state_q == REFILL_R);
endmodule

// File: doc/dcache_wb_controller.md
DCACHE_WB_CONTROLLER -- requirements
Module: dcache_wb_controller

Interface
REQ-001 LINE_INDEX_WIDTH, default 8, log2 of line count (direct-mapped).
REQ-002 WORD_INDEX_WIDTH, default 3, log2 of 32-bit words per line; minimum 1; BEATS = 2**WORD_INDEX_WIDTH/2 64-bit RAM beats per line.
REQ-003 TAG_WIDTH, derived, 30-LINE_INDEX_WIDTH-WORD_INDEX_WIDTH.
REQ-004 clk  in  1  sole clock, rising edge.
REQ-005 rst  in  1  reset, asynchronous, active-high.
REQ-006 req_valid  in  1  LSU request present.
REQ-007 req_ready  out  1  request accepted when req_valid&req_ready.
REQ-008 req_we  in  1  1 = store, 0 = load.
REQ-009 req_addr  in  32  byte address; bits [1:0] ignored.
REQ-010 req_wdata  in  32  store data.
REQ-011 req_wstrb  in  4  store byte enables.
REQ-012 resp_valid  out  1  one-cycle completion pulse; LSU is always ready.
REQ-013 resp_rdata  out  32  load data, valid with resp_valid; 0 for stores.
REQ-014 m_awaddr/m_awlen/m_awvalid/m_awready  out/out/out/in  32/8/1/1  write-back address channel, INCR, size 8 B.
REQ-015 m_wdata/m_wstrb/m_wlast/m_wvalid/m_wready  out/out/out/out/in  64/8/1/1/1  write-back data channel.
REQ-016 m_bvalid/m_bready  in/out  1/1  write response; m_bready SHALL be 1 only in WB_B.
REQ-017 m_araddr/m_arlen/m_arvalid/m_arready  out/out/out/in  32/8/1/1  refill address channel, INCR, size 8 B.
REQ-018 m_rdata/m_rlast/m_rvalid/m_rready  in/in/in/out  64/1/1/1  refill data; m_rready SHALL be 1 only in REFILL_R.

Function
REQ-019 Write-back, write-allocate, direct-mapped; per-line valid and dirty bits in flops; tag and data in synchronous single-port RAM with one-cycle read latency and byte write enables.
REQ-020 States: IDLE, LOOKUP, WB_AW, WB_W, WB_B, REFILL_AR, REFILL_R, REFILL_WR; encoding free.
REQ-021 req_ready SHALL be 1 only in IDLE; on acceptance addr/we/wdata/wstrb are latched and state -> LOOKUP.
REQ-022 LOOKUP hit (valid & tag match): load -> resp_valid=1 next cycle with word req_addr[WORD_INDEX_WIDTH+1:2]; store -> bytes written per wstrb, dirty set, resp_valid=1 next cycle; state -> IDLE. Hit latency: accept in cycle N, resp_valid in cycle N+2.
REQ-023 LOOKUP miss with valid&dirty victim -> WB_AW; otherwise -> REFILL_AR.
REQ-024 WB_AW: m_awvalid=1, m_awaddr={victim tag, index, 0s}, m_awlen=BEATS-1; hold stable until m_awready -> WB_W.
REQ-025 WB_W: beat k carries victim line bits [64k+63:64k], m_wstrb=8'hFF, m_wlast on k=BEATS-1; beat advances only on m_wvalid&m_wready; after last -> WB_B.
REQ-026 WB_B: on m_bvalid -> REFILL_AR; bresp ignored.
REQ-027 REFILL_AR: m_arvalid=1, m_araddr={req tag, index, 0s}, m_arlen=BEATS-1; hold until m_arready -> REFILL_R.
REQ-028 REFILL_R: beat k stored at line bits [64k+63:64k] on m_rvalid; on m_rlast -> REFILL_WR writing line and tag, setting valid, clearing dirty; then -> LOOKUP (replay guaranteed hit).
REQ-029 Beat counter WORD_INDEX_WIDTH-1 bits wide, cleared on entry to WB_W and REFILL_R.
REQ-030 No request accepted while any miss is outstanding; at most one AXI transaction in flight; AW never overlaps W.

Reset
REQ-031 rst asserted (any cycle, including mid-burst): state=IDLE, all valid and dirty=0, beat counter=0, resp_valid=0, all m_*valid=0, m_bready=0, m_rready=0, req_ready=1 after deassertion; in-flight RAM transaction abandoned, RAM model reset with it.

Verification
REQ-032 Load 0x0000_1000 after reset -> miss, AR addr 0x1000 len 3, 4 beats, resp_rdata = RAM word at 0x1000, no AW.
REQ-033 Repeat load 0x0000_1004 -> hit, resp_valid exactly 2 cycles after acceptance, no AXI activity.
REQ-034 Store 0xAABBCCDD wstrb 4'b0101 to 0x1008, then load 0x1008 -> 0x00BB00DD merged with old bytes, no AW issued.
REQ-035 Load 0x0000_3000 (same index, new tag) -> AW addr 0x1000 len 3, 4 W beats with wlast on beat 3 containing the store, then AR 0x3000.
REQ-036 m_awready, m_wready, m_arready, m_rvalid held low 5 cycles each -> valids and addresses stay stable; final data correct.
REQ-037 rst pulsed during REFILL_R beat 2 -> all outputs at reset values same cycle; next load 0x1000 misses again.
